way_hit_encoder: RTL and testbench

//   Parametrised, registered successor to the 4-way one-hot way encoder.

---
 rtl/way_hit_encoder.sv | 103 ++++++++++
 tb/tb_way_hit_encoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/way_hit_encoder.sv
// Registered hit-vector to way-index encoder with a 2-entry skid buffer.
// Optional saturating multi-hit counter enabled by defining WAY_ENC_ERR_CNT_EN.
module way_hit_encoder #(
  parameter int WAYS = 4
`ifdef WAY_ENC_ERR_CNT_EN
  , parameter int ERR_CNT_W = 8
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WAYS-1:0]           in_hit,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(WAYS)-1:0]   out_idx,
  output logic                      out_hit,
  output logic                      out_multi
`ifdef WAY_ENC_ERR_CNT_EN
  , output logic [ERR_CNT_W-1:0]    err_cnt
`endif
);

  localparam int IDX_W = $clog2(WAYS);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic             multi;
  } entry_t;

  // Handshake: a transfer happens on a posedge where valid && ready are both
  // high; the producer holds valid and its payload until that edge.

  entry_t     enc;
  logic [5:0] pop_cnt;
  logic       accept;

  entry_t m_e, s_e;
  logic   m_v, s_v;

  always_comb begin
    enc     = '0;
    pop_cnt = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (in_hit[i]) begin
        enc.idx = IDX_W'(i);
      end
      pop_cnt = pop_cnt + 6'(in_hit[i]);
    end
    enc.hit   = |in_hit;
    enc.multi = (pop_cnt >= 6'd2);
  end

  assign in_ready = !s_v && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_v <= 1'b0;
      m_e <= '0;
      s_v <= 1'b0;
      s_e <= '0;
    end else begin
      if (m_v && out_ready) begin
        if (s_v) begin
          m_e <= s_e;
          s_v <= 1'b0;
        end else if (accept) begin
          m_e <= enc;
        end else begin
          m_v <= 1'b0;
        end
      end else if (!m_v) begin
        if (accept) begin
          m_v <= 1'b1;
          m_e <= enc;
        end
      end else if (accept) begin
        // Main entry is stalled: park the new result in the skid slot.
        s_v <= 1'b1;
        s_e <= enc;
      end
    end
  end

  assign out_valid = m_v;
  assign out_idx   = m_e.idx;
  assign out_hit   = m_e.hit;
  assign out_multi = m_e.multi;

`ifdef WAY_ENC_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (accept && enc.multi && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_way_hit_encoder.sv
// Self-checking bench for way_hit_encoder: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_way_hit_encoder;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_hit;
  logic [1:0] out_idx;
  logic       out_hit, out_multi;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] in_hit8;
  logic [2:0] out_idx8;
  logic       out_hit8, out_multi8;

`ifdef WAY_ENC_ERR_CNT_EN
  logic [1:0] err_cnt;
  logic [7:0] err_cnt8;
`endif

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];

  way_hit_encoder #(
    .WAYS(4)
`ifdef WAY_ENC_ERR_CNT_EN
    , .ERR_CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_hit(in_hit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_hit(out_hit), .out_multi(out_multi)
`ifdef WAY_ENC_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  way_hit_encoder #(
    .WAYS(8)
  ) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_hit(in_hit8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_idx(out_idx8), .out_hit(out_hit8), .out_multi(out_multi8)
`ifdef WAY_ENC_ERR_CNT_EN
    , .err_cnt(err_cnt8)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: isolate the lowest set bit arithmetically, take its log2;
  // multi-hit means clearing the lowest set bit leaves something behind.
  function automatic logic [3:0] model4(input logic [3:0] h);
    logic [3:0] low;
    low = h & (~h + 4'd1);
    return {2'($clog2(low)), (h != 4'd0), ((h & (h - 4'd1)) != 4'd0)};
  endfunction

  function automatic logic [4:0] model8(input logic [7:0] h);
    logic [7:0] low;
    low = h & (~h + 8'd1);
    return {3'($clog2(low)), (h != 8'd0), ((h & (h - 8'd1)) != 8'd0)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_hit = 4'b0100; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    total++; if ({out_valid, out_idx, out_hit, out_multi} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs: got %05b want 00000", {out_valid, out_idx, out_hit, out_multi});
    end
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid8: got %0b want 0", out_valid8); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want;
    out_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      #1;
      if (k > 0) begin
        want = {2'(k - 1), 1'b1, 1'b0};
        total++; if ({out_idx, out_hit, out_multi} !== want || out_valid !== 1'b1) begin
          bad++; $display("FAIL b2b_out%0d: got v=%0b %04b want v=1 %04b", k - 1, out_valid, {out_idx, out_hit, out_multi}, want);
        end
      end
      if (k < 4) begin
        in_valid = 1'b1; in_hit = 4'(1 << k);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %0b want 1", k, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_encode();
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_hit = 4'b0000;
    @(negedge clk); in_hit = 4'b0110; #1;
    total++; if ({out_valid, out_idx, out_hit, out_multi} !== 5'b1_00_0_0) begin
      bad++; $display("FAIL enc_zero: got %05b want 10000", {out_valid, out_idx, out_hit, out_multi});
    end
    @(negedge clk); in_valid = 1'b0; #1;
    total++; if ({out_valid, out_idx, out_hit, out_multi} !== 5'b1_01_1_1) begin
      bad++; $display("FAIL enc_multi: got %05b want 10111", {out_valid, out_idx, out_hit, out_multi});
    end
    @(negedge clk); #1;
  endtask

  task automatic test_stall();
    logic [3:0] got;
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_hit = 4'b0001; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready0: got %0b want 1", in_ready); end
    @(negedge clk); in_hit = 4'b0100; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready1: got %0b want 1", in_ready); end
    @(negedge clk); in_hit = 4'b1000; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready2: got %0b want 0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      got = {out_idx, out_hit, out_multi};
      total++; if (out_valid !== 1'b1 || got !== 4'b00_1_0 || in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d: got v=%0b r=%0b %04b want v=1 r=0 0010", c, out_valid, in_ready, got);
      end
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b1 || {out_idx, out_hit, out_multi} !== 4'b10_1_0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_second: got v=%0b r=%0b %04b want v=1 r=1 1010", out_valid, in_ready, {out_idx, out_hit, out_multi});
    end
    @(negedge clk); in_valid = 1'b0; #1;
    total++; if (out_valid !== 1'b1 || {out_idx, out_hit, out_multi} !== 4'b11_1_0) begin
      bad++; $display("FAIL stall_third: got v=%0b %04b want v=1 1110", out_valid, {out_idx, out_hit, out_multi});
    end
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty: got %0b want 0", out_valid); end
  endtask

  task automatic test_ways8(input int n);
    logic       pv;
    logic [4:0] pe;
    logic [7:0] h;
    pv = 1'b0; pe = '0; out_ready8 = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk); #1;
      total++; if (out_valid8 !== pv) begin bad++; $display("FAIL w8_valid%0d: got %0b want %0b", c, out_valid8, pv); end
      if (pv) begin
        total++; if ({out_idx8, out_hit8, out_multi8} !== pe) begin
          bad++; $display("FAIL w8_data%0d: got %05b want %05b", c, {out_idx8, out_hit8, out_multi8}, pe);
        end
      end
      total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL w8_ready%0d: got %0b want 1", c, in_ready8); end
      if (c == 0) h = 8'h80;
      else if (c == 1) h = 8'hA0;
      else h = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      in_valid8 = (c < 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_hit8 = h;
      pv = in_valid8;
      pe = model8(h);
    end
    @(negedge clk); in_valid8 = 1'b0;
  endtask

  task automatic test_random(input int n);
    logic [3:0] h;
    logic       acc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      h = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      in_hit = h;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc = in_valid && (exp_q.size() < 2);
      total++; if (out_valid !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL rnd_valid%0d: got %0b want %0b", c, out_valid, exp_q.size() != 0);
      end
      total++; if (in_ready !== (exp_q.size() < 2)) begin
        bad++; $display("FAIL rnd_ready%0d: got %0b want %0b", c, in_ready, exp_q.size() < 2);
      end
      if (exp_q.size() != 0) begin
        total++; if ({out_idx, out_hit, out_multi} !== exp_q[0]) begin
          bad++; $display("FAIL rnd_data%0d: got %04b want %04b", c, {out_idx, out_hit, out_multi}, exp_q[0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
      if (acc) exp_q.push_back(model4(h));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      @(negedge clk); #1;
      total++; if (out_valid !== 1'b1 || {out_idx, out_hit, out_multi} !== exp_q[0]) begin
        bad++; $display("FAIL rnd_drain%0d: got v=%0b %04b want v=1 %04b", c, out_valid, {out_idx, out_hit, out_multi}, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++; $display("FAIL rnd_empty: got v=%0b q=%0d want v=0 q=0", out_valid, exp_q.size());
    end
    exp_q.delete();
  endtask

`ifdef WAY_ENC_ERR_CNT_EN
  task automatic test_err_cnt();
    logic [1:0] want;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    total++; if (err_cnt !== 2'd0) begin bad++; $display("FAIL err_reset: got %0d want 0", err_cnt); end
    want = 2'd0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); in_valid = 1'b1;
      in_hit = (k == 5) ? 4'b0010 : 4'b0110 | 4'(1 << $urandom_range(0, 3));
      if (k != 5 && want != 2'd3) want = want + 2'd1;
      @(negedge clk); in_valid = 1'b0; #1;
      total++; if (err_cnt !== want) begin bad++; $display("FAIL err_cnt%0d: got %0d want %0d", k, err_cnt, want); end
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    total++; if (err_cnt !== 2'd0) begin bad++; $display("FAIL err_clear: got %0d want 0", err_cnt); end
  endtask
`endif

  task automatic test_reset_mid();
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_hit = 4'b0001;
    @(negedge clk); in_hit = 4'b0010;
    @(negedge clk); in_hit = 4'b0100; #1;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL mid_full: got r=%0b v=%0b want r=0 v=1", in_ready, out_valid);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got v=%0b r=%0b want v=0 r=0", out_valid, in_ready);
    end
    rst = 1'b0; in_valid = 1'b1; in_hit = 4'b0100; out_ready = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %0b want 1", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    total++; if ({out_valid, out_idx, out_hit, out_multi} !== 5'b1_10_1_0) begin
      bad++; $display("FAIL mid_after: got %05b want 11010", {out_valid, out_idx, out_hit, out_multi});
    end
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_single: got %0b want 0", out_valid); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_hit = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_hit8 = '0; out_ready8 = 1'b1;
    test_reset();
    test_back_to_back();
    test_encode();
    test_stall();
    test_ways8(60);
    test_random(400);
`ifdef WAY_ENC_ERR_CNT_EN
    test_err_cnt();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
